alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Parametrised, handshaked MIPS execute stage: decodes `aluop`/`func` into an internal 4-bit ALU control code and executes the operation on `WIDTH`-bit operands. Single-cycle ops complete in one cycle. `MULTU`, and `DIVU` when configured, run on an iterative sequencer. Sits between the decode/register-read stage and memory/writeback. Valid/ready handshakes on both sides allow either neighbour to stall.

## Interface
- `WIDTH`, 32: operand/result width; power of two, ≥8.
- `SHW`, `$clog2(WIDTH)`: shift-amount width (derived; do not override).

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operation presented.
- `in_ready` out 1: block accepts the operation this cycle.
- `aluop` in 2: `00` R-type (use `func`), `01` ADD (lw/sw), `10` SUB compare (beq/bne), `11` OR (ori).
- `func` in 6: R-type function field.
- `op_a`, `op_b` in WIDTH: operands (rs, rt/imm).
- `shamt` in SHW: shift amount.
- `out_valid` out 1: result held and valid.
- `out_ready` in 1: consumer takes the result.
- `result` out WIDTH: main result; product low half or quotient.
- `hi` out WIDTH: product high half or remainder; 0 for other ops.
- `zero` out 1: `result == 0`.
- `illegal` out 1: unrecognised `func`.
- `div0` out 1: DIVU with `op_b == 0`.

## Operation
- Decoded R-type funcs:
  - ADD `100000`, SUB `100010`, AND `100100`, OR `100101`, XOR `100110`, NOR `100111`.
  - SLL `000000`, SRL `000010`, SRA `000011`.
  - SLT `101010` (signed compare), SLTU `101011`.
  - MULTU `011001`, DIVU `011011`.
- Any other R-type func: result 0, `hi` 0, `illegal` 1; completes as a single-cycle op. Decode is purely combinational; no latch and no retention of the previous func.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH; no overflow trap.
  - SLT/SLTU produce 0 or 1 in bit 0.
  - Shifts use `shamt` only; SRA replicates `op_a[WIDTH-1]`.
  - MULTU: unsigned 2·WIDTH product split `{hi,result}`.
  - DIVU: unsigned; `result` = quotient, `hi` = remainder.
  - DIVU with `op_b == 0`: `result` = all ones, `hi` = `op_a`, `div0` 1, single-cycle latency.
- FSM states and transitions:
  - IDLE: accept when `in_valid && in_ready`. Single-cycle op loads the output register and stays in IDLE. MULTU or DIVU (divisor ≠0) loads the sequencer, sets the counter to WIDTH and goes to BUSY.
  - BUSY: one shift-add or restoring-subtract step per cycle; counter decrements; goes to DONE when the counter reaches 0. `in_ready` = 0.
  - DONE: loads the output register when the slot is free (`!out_valid || out_ready`), then goes to IDLE; otherwise holds. `in_ready` = 0.
- `in_ready = (state == IDLE) && (!out_valid || out_ready)`.
- Output register: loads as described above; clears `out_valid` on `out_ready` when there is no simultaneous load. `result`, `hi` and the flags are stable while `out_valid && !out_ready`.

## Timing
- Reset values: state IDLE, `out_valid` 0, `result` 0, `hi` 0, `zero` 1, `illegal` 0, `div0` 0, counter 0. `in_ready` is 1 in the cycle after reset.
- Latency, measured from the accept edge to `out_valid` high:
  - Single-cycle ops: 1 cycle. Sustained throughput of 1 op per cycle while `out_ready` = 1.
  - MULTU/DIVU: WIDTH+1 cycles at minimum; extended by each cycle DONE is stalled on a full output register.
- Simultaneous consume and accept in the same cycle: the new result replaces the old one with no bubble.
- `rst` mid-operation: the in-flight op is discarded and the held result is dropped; all outputs take their reset values on the next edge.
- `in_valid` while `in_ready` = 0: ignored. The upstream stage must hold its inputs until accepted.

## Configuration
- `MIPS_ALU_DIV_EN` defined: the DIVU datapath and the restoring steps are compiled in.
- `MIPS_ALU_DIV_EN` undefined: func `011011` decodes as illegal (result 0, `illegal` 1, 1-cycle latency); `div0` is tied to 0. MULTU is unaffected.

## Structure
- Package `alu_pkg` holds:
  - Func constants and the `aluop` enum.
  - The `alu_ctrl_e` 4-bit control-code enum: ADD 0, SUB 1, AND 2, OR 3, SLL 4, SRL 5, SLT 6, SUBCMP 7, ORI 8, XOR 9, NOR 10, SRA 11, SLTU 12, MUL 13, DIV 14, ILL 15.
  - The FSM state enum.
- Sub-module `alu_muldiv_iter` contains the iterative multiply/divide datapath and counter. It receives start/op/operands and returns done/lo/hi. The top level owns decode, the single-cycle ALU, the FSM and the output register.

## Test plan
- Reset, then ADD 7+5 with `out_ready` = 1 → `result` 12, `zero` 0, `out_valid` exactly 1 cycle after accept; SUB 5−5 → `zero` 1.
- Back-to-back ops SLL 1<<31, SRA `0x80000000`>>4, SLT −1<0 → results `0x80000000`, `0xF8000000`, 1, one per cycle with no bubbles.
- MULTU `0xFFFFFFFF` × 2 → `hi` 1, `result` `0xFFFFFFFE`, `out_valid` 33 cycles after accept; `in_ready` 0 throughout.
- DIVU 100/7 → `result` 14, `hi` 2; DIVU x/0 → all ones, `hi` = x, `div0` 1, 1-cycle latency. Without the macro, func `011011` → `illegal` 1.
- Hold `out_ready` = 0 during MULTU with the previous result still pending → FSM holds in DONE, previous result stays stable, no loss once `out_ready` rises.
- Func `111111` → `illegal` 1, `result` 0; assert `rst` mid-MULTU → `out_valid` 0 and `in_ready` 1 on the next cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the MIPS execute stage: R-type function codes, the
// aluop encoding, the internal 4-bit ALU control code, the sequencing FSM
// states and the aluop/func -> control-code decoder.
// Build option: MIPS_ALU_DIV_EN (DIVU support) is passed to decode_ctrl as
// the div_en argument by the top level.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [5:0] FUNC_SLL   = 6'b000000;
    localparam logic [5:0] FUNC_SRL   = 6'b000010;
    localparam logic [5:0] FUNC_SRA   = 6'b000011;
    localparam logic [5:0] FUNC_MULTU = 6'b011001;
    localparam logic [5:0] FUNC_DIVU  = 6'b011011;
    localparam logic [5:0] FUNC_ADD   = 6'b100000;
    localparam logic [5:0] FUNC_SUB   = 6'b100010;
    localparam logic [5:0] FUNC_AND   = 6'b100100;
    localparam logic [5:0] FUNC_OR    = 6'b100101;
    localparam logic [5:0] FUNC_XOR   = 6'b100110;
    localparam logic [5:0] FUNC_NOR   = 6'b100111;
    localparam logic [5:0] FUNC_SLT   = 6'b101010;
    localparam logic [5:0] FUNC_SLTU  = 6'b101011;

    typedef enum logic [1:0] {
        ALUOP_RTYPE = 2'b00,
        ALUOP_ADD   = 2'b01,
        ALUOP_SUB   = 2'b10,
        ALUOP_OR    = 2'b11
    } aluop_e;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_SLL    = 4'd4,
        ALU_SRL    = 4'd5,
        ALU_SLT    = 4'd6,
        ALU_SUBCMP = 4'd7,
        ALU_ORI    = 4'd8,
        ALU_XOR    = 4'd9,
        ALU_NOR    = 4'd10,
        ALU_SRA    = 4'd11,
        ALU_SLTU   = 4'd12,
        ALU_MUL    = 4'd13,
        ALU_DIV    = 4'd14,
        ALU_ILL    = 4'd15
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Pure combinational decode; unknown funcs (and DIVU when not built in)
    // map to ALU_ILL so nothing from a previous operation is retained.
    function automatic alu_ctrl_e decode_ctrl(input logic [1:0] aluop,
                                              input logic [5:0] func,
                                              input logic       div_en);
        alu_ctrl_e ctrl;
        ctrl = ALU_ILL;
        case (aluop)
            ALUOP_ADD: ctrl = ALU_ADD;
            ALUOP_SUB: ctrl = ALU_SUBCMP;
            ALUOP_OR:  ctrl = ALU_ORI;
            ALUOP_RTYPE: begin
                case (func)
                    FUNC_ADD:   ctrl = ALU_ADD;
                    FUNC_SUB:   ctrl = ALU_SUB;
                    FUNC_AND:   ctrl = ALU_AND;
                    FUNC_OR:    ctrl = ALU_OR;
                    FUNC_XOR:   ctrl = ALU_XOR;
                    FUNC_NOR:   ctrl = ALU_NOR;
                    FUNC_SLL:   ctrl = ALU_SLL;
                    FUNC_SRL:   ctrl = ALU_SRL;
                    FUNC_SRA:   ctrl = ALU_SRA;
                    FUNC_SLT:   ctrl = ALU_SLT;
                    FUNC_SLTU:  ctrl = ALU_SLTU;
                    FUNC_MULTU: ctrl = ALU_MUL;
                    FUNC_DIVU:  ctrl = div_en ? ALU_DIV : ALU_ILL;
                    default:    ctrl = ALU_ILL;
                endcase
            end
            default: ctrl = ALU_ILL;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// ---------------------------------------------------------------------------
// alu_muldiv_iter
// Iterative unsigned multiplier (shift-add) and, when MIPS_ALU_DIV_EN is
// defined, restoring divider. One step per clock; the start edge itself
// performs the first step, so WIDTH steps finish WIDTH-1 edges after start.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : load operands (and take the first step)
//   is_div     : 1 = divide, 0 = multiply (ignored without MIPS_ALU_DIV_EN)
//   a, b       : multiplicand/dividend, multiplier/divisor
//   done       : the current edge performs the final step
//   lo, hi     : product {hi,lo}, or quotient (lo) / remainder (hi)
// ---------------------------------------------------------------------------
module alu_muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

    // count_r holds the number of steps still to perform
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc_src_s;
    logic [WIDTH-1:0] q_src_s;
    logic [WIDTH-1:0] b_src_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] acc_next_s;
    logic [WIDTH-1:0] q_next_s;
    logic             div_src_s;
`ifdef MIPS_ALU_DIV_EN
    logic             is_div_r;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   diff_s;
`else
    logic             div_unused_s;
    assign div_unused_s = is_div;
`endif

    // Step source: fresh operands on the start edge, otherwise the registers
    always_comb begin
        acc_src_s = acc_r;
        q_src_s   = q_r;
        b_src_s   = b_r;
        if (start) begin
            acc_src_s = ZERO_W;
            q_src_s   = a;
            b_src_s   = b;
`ifdef MIPS_ALU_DIV_EN
            div_src_s = is_div;
        end else begin
            div_src_s = is_div_r;
        end
`else
            div_src_s = 1'b0;
        end else begin
            div_src_s = 1'b0;
        end
`endif
    end

    // One iteration: shift-add for multiply, restoring subtract for divide
    always_comb begin
        // Multiply: add the multiplicand when the multiplier LSB is set, then
        // shift {carry, acc, q} right; q collects product bits from the top.
        sum_s      = {1'b0, acc_src_s} + (q_src_s[0] ? {1'b0, b_src_s} : {1'b0, ZERO_W});
        acc_next_s = sum_s[WIDTH:1];
        q_next_s   = {sum_s[0], q_src_s[WIDTH-1:1]};
`ifdef MIPS_ALU_DIV_EN
        // Divide: remainder stays below the divisor so it fits in WIDTH bits;
        // bit WIDTH of the difference is the borrow.
        shifted_s = {acc_src_s, q_src_s[WIDTH-1]};
        diff_s    = shifted_s - {1'b0, b_src_s};
        if (div_src_s) begin
            if (!diff_s[WIDTH]) begin
                acc_next_s = diff_s[WIDTH-1:0];
                q_next_s   = {q_src_s[WIDTH-2:0], 1'b1};
            end else begin
                acc_next_s = shifted_s[WIDTH-1:0];
                q_next_s   = {q_src_s[WIDTH-2:0], 1'b0};
            end
        end else begin
            shifted_s = {acc_src_s, q_src_s[WIDTH-1]};
        end
`endif
    end

    // Datapath and step counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r  <= {CW{1'b0}};
            acc_r    <= ZERO_W;
            q_r      <= ZERO_W;
            b_r      <= ZERO_W;
`ifdef MIPS_ALU_DIV_EN
            is_div_r <= 1'b0;
`endif
        end else if (start || (count_r != {CW{1'b0}})) begin
            acc_r    <= acc_next_s;
            q_r      <= q_next_s;
            b_r      <= b_src_s;
            count_r  <= start ? CW'(WIDTH - 1) : (count_r - CW'(1));
`ifdef MIPS_ALU_DIV_EN
            is_div_r <= div_src_s;
`endif
        end
    end

    assign done = (count_r == CW'(1));
    assign lo   = q_r;
    assign hi   = acc_r;

endmodule

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
// Handshaked MIPS execute stage. Decodes aluop/func, runs single-cycle ALU
// ops directly into the output register and hands MULTU/DIVU to the
// iterative sequencer (alu_muldiv_iter).
// Build option: MIPS_ALU_DIV_EN compiles in DIVU; otherwise DIVU is illegal
// and div0 stays 0.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : upstream handshake; aluop, func, op_a, op_b, shamt
//   out_valid/out_ready : downstream handshake; result, hi, zero, illegal, div0
// ---------------------------------------------------------------------------
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       aluop,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             illegal,
    output logic             div0
);

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
`ifdef MIPS_ALU_DIV_EN
    localparam logic DIV_EN = 1'b1;
`else
    localparam logic DIV_EN = 1'b0;
`endif

    state_e           state_r, state_next_s;
    alu_ctrl_e        ctrl_s;
    logic [WIDTH-1:0] alu_res_s, alu_hi_s, seq_lo_s, seq_hi_s;
    logic             alu_ill_s, alu_div0_s, is_seq_s;
    logic             slot_free_s, in_ready_s, accept_s, start_s;
    logic             load_single_s, load_seq_s, seq_done_s;
    logic [WIDTH-1:0] result_r, hi_r;
    logic             out_valid_r, zero_r, illegal_r, div0_r;

    assign ctrl_s        = decode_ctrl(aluop, func, DIV_EN);
    assign slot_free_s   = !out_valid_r || out_ready;
    assign accept_s      = in_valid && in_ready_s;
    assign start_s       = accept_s && is_seq_s;
    assign load_single_s = accept_s && !is_seq_s;

    // Single-cycle ALU; MULTU/DIVU results come from the sequencer instead
    always_comb begin
        alu_res_s  = ZERO_W;
        alu_hi_s   = ZERO_W;
        alu_ill_s  = 1'b0;
        alu_div0_s = 1'b0;
        case (ctrl_s)
            ALU_ADD:             alu_res_s = op_a + op_b;
            ALU_SUB, ALU_SUBCMP: alu_res_s = op_a - op_b;
            ALU_AND:             alu_res_s = op_a & op_b;
            ALU_OR, ALU_ORI:     alu_res_s = op_a | op_b;
            ALU_XOR:             alu_res_s = op_a ^ op_b;
            ALU_NOR:             alu_res_s = ~(op_a | op_b);
            ALU_SLL:             alu_res_s = op_a << shamt;
            ALU_SRL:             alu_res_s = op_a >> shamt;
            ALU_SRA:             alu_res_s = $unsigned($signed(op_a) >>> shamt);
            ALU_SLT:             alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU:            alu_res_s = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            ALU_MUL:             alu_res_s = ZERO_W;
`ifdef MIPS_ALU_DIV_EN
            ALU_DIV: begin
                // Divide by zero finishes immediately with the MIPS-style result
                if (op_b == ZERO_W) begin
                    alu_res_s  = ONES_W;
                    alu_hi_s   = op_a;
                    alu_div0_s = 1'b1;
                end else begin
                    alu_res_s  = ZERO_W;
                end
            end
`else
            ALU_DIV:             alu_ill_s = 1'b1;
`endif
            ALU_ILL:             alu_ill_s = 1'b1;
            default:             alu_ill_s = 1'b1;
        endcase
    end

    // Route MULTU and non-zero-divisor DIVU to the sequencer
    always_comb begin
        if (ctrl_s == ALU_MUL) begin
            is_seq_s = 1'b1;
        end else if ((ctrl_s == ALU_DIV) && (op_b != ZERO_W)) begin
            is_seq_s = 1'b1;
        end else begin
            is_seq_s = 1'b0;
        end
    end

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (start_s),
        .is_div (ctrl_s == ALU_DIV),
        .a      (op_a),
        .b      (op_b),
        .done   (seq_done_s),
        .lo     (seq_lo_s),
        .hi     (seq_hi_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: state_next_s = start_s     ? ST_BUSY : ST_IDLE;
            ST_BUSY: state_next_s = seq_done_s  ? ST_DONE : ST_BUSY;
            ST_DONE: state_next_s = slot_free_s ? ST_IDLE : ST_DONE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs: accept only in IDLE, unload the sequencer only in DONE
    always_comb begin
        in_ready_s = 1'b0;
        load_seq_s = 1'b0;
        case (state_r)
            ST_IDLE: in_ready_s = slot_free_s;
            ST_BUSY: in_ready_s = 1'b0;
            ST_DONE: load_seq_s = slot_free_s;
            default: in_ready_s = 1'b0;
        endcase
    end

    // Output register; data holds while out_valid && !out_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            result_r    <= ZERO_W;
            hi_r        <= ZERO_W;
            zero_r      <= 1'b1;
            illegal_r   <= 1'b0;
            div0_r      <= 1'b0;
        end else if (load_single_s) begin
            out_valid_r <= 1'b1;
            result_r    <= alu_res_s;
            hi_r        <= alu_hi_s;
            zero_r      <= (alu_res_s == ZERO_W);
            illegal_r   <= alu_ill_s;
            div0_r      <= alu_div0_s;
        end else if (load_seq_s) begin
            out_valid_r <= 1'b1;
            result_r    <= seq_lo_s;
            hi_r        <= seq_hi_s;
            zero_r      <= (seq_lo_s == ZERO_W);
            illegal_r   <= 1'b0;
            div0_r      <= 1'b0;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign hi        = hi_r;
    assign zero      = zero_r;
    assign illegal   = illegal_r;
    assign div0      = div0_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
// Directed bench for alu_exec_unit (WIDTH=32). A behavioural model computes
// each accepted operation's outputs with plain arithmetic; a scoreboard
// queue holds them until consumed and is compared against the DUT on every
// cycle out_valid is high. Hand-computed literals pin the model and timing.
// Honours MIPS_ALU_DIV_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

`ifdef MIPS_ALU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  aluop;
    logic [5:0]  func;
    logic [31:0] op_a, op_b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result, hi;
    logic        zero, illegal, div0;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] hi;
        logic        ill;
        logic        d0;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluop     (aluop),
        .func      (func),
        .op_a      (op_a),
        .op_b      (op_b),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .hi        (hi),
        .zero      (zero),
        .illegal   (illegal),
        .div0      (div0)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Behavioural model of one operation
    function automatic exp_t model(input logic [1:0] op, input logic [5:0] fn,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] sh);
        exp_t        e;
        logic [63:0] p;
        e = '0;
        p = 64'd0;
        if (op == 2'd1)      e.res = a + b;
        else if (op == 2'd2) e.res = a - b;
        else if (op == 2'd3) e.res = a | b;
        else begin
            case (fn)
                6'd32: e.res = a + b;
                6'd34: e.res = a - b;
                6'd36: e.res = a & b;
                6'd37: e.res = a | b;
                6'd38: e.res = a ^ b;
                6'd39: e.res = ~(a | b);
                6'd0:  e.res = a << sh;
                6'd2:  e.res = a >> sh;
                6'd3:  e.res = $unsigned($signed(a) >>> sh);
                6'd42: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                6'd43: e.res = (a < b) ? 32'd1 : 32'd0;
                6'd25: begin
                    p = {32'd0, a} * {32'd0, b};
                    e.res = p[31:0];
                    e.hi  = p[63:32];
                end
                6'd27: begin
                    if (!DIV_EN) e.ill = 1'b1;
                    else if (b == 32'd0) begin
                        e.res = 32'hFFFF_FFFF;
                        e.hi  = a;
                        e.d0  = 1'b1;
                    end else begin
                        e.res = a / b;
                        e.hi  = a % b;
                    end
                end
                default: e.ill = 1'b1;
            endcase
        end
        return e;
    endfunction

    // Scoreboard bookkeeping on each active edge (pre-edge values)
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready && (exp_q.size() > 0)) void'(exp_q.pop_front());
            if (in_valid && in_ready) exp_q.push_back(model(aluop, func, op_a, op_b, shamt));
        end
    end

    // Compare process: every cycle the output is valid
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_spurious: got out_valid=1 with result %h, expected no output", result);
            end else begin
                chk("sb_result",  result, exp_q[0].res);
                chk("sb_hi",      hi,     exp_q[0].hi);
                chk("sb_zero",    {31'd0, zero},    {31'd0, (exp_q[0].res == 32'd0)});
                chk("sb_illegal", {31'd0, illegal}, {31'd0, exp_q[0].ill});
                chk("sb_div0",    {31'd0, div0},    {31'd0, exp_q[0].d0});
            end
        end
    end

    task automatic sync;
        @(posedge clk);
        #1;
    endtask

    // Present one op and hold it until accepted (bounded)
    task automatic send(input logic [1:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        int n;
        sync();
        aluop = op; func = fn; op_a = a; op_b = b; shamt = sh;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Cycles from the accept edge until out_valid is seen; also counts
    // cycles where in_ready was high before the result appeared
    task automatic wait_out(output int lat, output int rdy_hits);
        lat = 0;
        rdy_hits = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid && in_ready) rdy_hits++;
        end while (!out_valid && lat < 100);
    endtask

    typedef struct packed {
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int lat, rdy, stale;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        aluop = 2'd0; func = 6'd0; op_a = 32'd0; op_b = 32'd0; shamt = 5'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result",    result,             32'd0);
        chk("rst_hi",        hi,                 32'd0);
        chk("rst_zero",      {31'd0, zero},      32'd1);
        chk("rst_illegal",   {31'd0, illegal},   32'd0);
        chk("rst_div0",      {31'd0, div0},      32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);

        // ADD 7+5, SUB 5-5
        send(2'b00, 6'b100000, 32'd7, 32'd5, 5'd0);
        wait_out(lat, rdy);
        chk("add_latency", 32'(lat), 32'd1);
        chk("add_result",  result, 32'd12);
        chk("add_zero",    {31'd0, zero}, 32'd0);
        send(2'b00, 6'b100010, 32'd5, 32'd5, 5'd0);
        wait_out(lat, rdy);
        chk("sub_result", result, 32'd0);
        chk("sub_zero",   {31'd0, zero}, 32'd1);

        // Back-to-back SLL, SRA, SLT with no bubbles
        sync();
        aluop = 2'b00; func = 6'b000000; op_a = 32'd1; op_b = 32'd0; shamt = 5'd31; in_valid = 1'b1;
        @(posedge clk); #1;
        func = 6'b000011; op_a = 32'h8000_0000; shamt = 5'd4;
        @(negedge clk);
        chk("b2b_sll", result, 32'h8000_0000);
        @(posedge clk); #1;
        func = 6'b101010; op_a = 32'hFFFF_FFFF; op_b = 32'd0; shamt = 5'd0;
        @(negedge clk);
        chk("b2b_sra", result, 32'hF800_0000);
        chk("b2b_valid_sra", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_slt", result, 32'd1);
        chk("b2b_valid_slt", {31'd0, out_valid}, 32'd1);

        // MULTU 0xFFFFFFFF * 2
        send(2'b00, 6'b011001, 32'hFFFF_FFFF, 32'd2, 5'd0);
        wait_out(lat, rdy);
        chk("mul_latency",  32'(lat), 32'd33);
        chk("mul_in_ready", 32'(rdy), 32'd0);
        chk("mul_hi",       hi,       32'd1);
        chk("mul_result",   result,   32'hFFFF_FFFE);

        // DIVU
`ifdef MIPS_ALU_DIV_EN
        send(2'b00, 6'b011011, 32'd100, 32'd7, 5'd0);
        wait_out(lat, rdy);
        chk("div_latency", 32'(lat), 32'd33);
        chk("div_result",  result, 32'd14);
        chk("div_hi",      hi,     32'd2);
        send(2'b00, 6'b011011, 32'h0000_1234, 32'd0, 5'd0);
        wait_out(lat, rdy);
        chk("div0_latency", 32'(lat), 32'd1);
        chk("div0_result",  result, 32'hFFFF_FFFF);
        chk("div0_hi",      hi,     32'h0000_1234);
        chk("div0_flag",    {31'd0, div0}, 32'd1);
`else
        send(2'b00, 6'b011011, 32'd100, 32'd7, 5'd0);
        wait_out(lat, rdy);
        chk("divoff_latency", 32'(lat), 32'd1);
        chk("divoff_illegal", {31'd0, illegal}, 32'd1);
        chk("divoff_result",  result, 32'd0);
`endif

        // Mixed single-cycle vectors, checked by the scoreboard
        vecs[0] = '{2'b01, 6'd0,        32'hFFFF_FFFF, 32'd1,         5'd0};
        vecs[1] = '{2'b11, 6'd0,        32'h0000_00F0, 32'h0000_000F, 5'd0};
        vecs[2] = '{2'b10, 6'd0,        32'd3,         32'd5,         5'd0};
        vecs[3] = '{2'b00, 6'b100100,   32'hF0F0_1234, 32'h0FF0_FF00, 5'd0};
        vecs[4] = '{2'b00, 6'b100110,   32'hAAAA_5555, 32'hFFFF_0000, 5'd0};
        vecs[5] = '{2'b00, 6'b100111,   32'h0000_00FF, 32'hFF00_0000, 5'd0};
        vecs[6] = '{2'b00, 6'b000010,   32'h8000_0000, 32'd0,         5'd31};
        vecs[7] = '{2'b00, 6'b101011,   32'd1,         32'hFFFF_FFFF, 5'd0};
        vecs[8] = '{2'b00, 6'b101010,   32'hFFFF_FFFF, 32'd1,         5'd0};
        vecs[9] = '{2'b00, 6'b100101,   32'h1200_0000, 32'h0000_0034, 5'd0};
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].sh);
        end
        wait_out(lat, rdy);
        chk("ori_pin", {31'd0, out_valid}, 32'd1);

        // Illegal func
        send(2'b00, 6'b111111, 32'd9, 32'd9, 5'd3);
        wait_out(lat, rdy);
        chk("ill_latency", 32'(lat), 32'd1);
        chk("ill_flag",    {31'd0, illegal}, 32'd1);
        chk("ill_result",  result, 32'd0);

        // MULTU with the consumer stalled: result must hold, then drain once
        send(2'b00, 6'b011001, 32'd3, 32'd5, 5'd0);
        out_ready = 1'b0;
        wait_out(lat, rdy);
        chk("stall_latency", 32'(lat), 32'd33);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_hold",  result, 32'd15);
            chk("stall_ready", {31'd0, in_ready}, 32'd0);
        end
        sync();
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("stall_drained", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of MULTU
        send(2'b00, 6'b011001, 32'd1234, 32'd5678, 5'd0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstmid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rstmid_in_ready",  {31'd0, in_ready},  32'd1);
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("rstmid_no_stale", 32'(stale), 32'd0);

        // One more op after the reset, then the scoreboard must be empty
        send(2'b01, 6'd0, 32'd40, 32'd2, 5'd0);
        wait_out(lat, rdy);
        chk("post_rst_add", result, 32'd42);
        @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
